// File: rtl/lms_ctr_mem_pkg.sv
// Shared state encoding and bus widths for the LMS control-memory access bridge.
package lms_ctr_mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/lms_ctr_mem_clear_seq.sv
// Zero-fill address sequencer: walks 0..DEPTH-1 while enabled and flags the last word.
module lms_ctr_mem_clear_seq
    import lms_ctr_mem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              enable,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    // One spare MSB so the count past the last word never aliases back to 0.
    logic [ADDR_W:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + ONE;
        end
    end

    assign addr = r_count[ADDR_W-1:0];
    assign done = (r_count == LAST_ADDR);

endmodule

// File: rtl/lms_ctr_mem_access_bridge.sv
// Upstream request bridge to a single-port RAM with reset-time and runtime zero-fill.
module lms_ctr_mem_access_bridge
    import lms_ctr_mem_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] s_address,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [BE_W-1:0]   s_byteenable,
    input  logic [DATA_W-1:0] s_writedata,
    output logic              s_waitrequest,
    output logic [DATA_W-1:0] s_readdata,
    output logic              s_readdatavalid,

    input  logic              clear_req,
    output logic              clear_busy,
    output logic              err_sticky,

    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [BE_W-1:0]   m_byteenable,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata
);

    if (DEPTH != (2 ** ADDR_W)) begin : g_bad_depth
        $error("lms_ctr_mem_access_bridge: DEPTH must equal 2**ADDR_W");
    end

    localparam bridge_state_t RESET_STATE =
        bridge_state_t'(CLEAR_ON_RESET ? ST_CLEAR : ST_RUN);

    bridge_state_t     r_state;
    bridge_state_t     w_next_state;
    logic              r_active;
    logic [1:0]        r_rd_pipe;
    logic [DATA_W-1:0] r_readdata;
    logic              r_err;

    logic              w_run;
    logic              w_rd_accept;
    logic              w_rw_clash;
    logic              w_clr_start;
    logic              w_clr_en;
    logic              w_clr_done;
    logic [ADDR_W-1:0] w_clr_addr;

    // r_active gates every output so the reset-state encoding never leaks
    // onto the buses while reset_n is low; it rises on the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    assign w_run       = r_active && (r_state == ST_RUN);
    assign w_rd_accept = w_run && s_read && !s_write;
    assign w_rw_clash  = w_run && s_read && s_write;
    assign w_clr_en    = r_active && (r_state == ST_CLEAR);
    assign w_clr_start = (r_state != ST_CLEAR);

    lms_ctr_mem_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_clr_start),
        .enable  (w_clr_en),
        .addr    (w_clr_addr),
        .done    (w_clr_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // DRAIN only waits for the read still needing the RAM (pipe[0]); a response
    // in pipe[1] is already captured and cannot be disturbed by clear writes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_en && w_clr_done) w_next_state = ST_RUN;
            ST_RUN:   if (w_run && clear_req)     w_next_state = ST_DRAIN;
            ST_DRAIN: if (!r_rd_pipe[0])          w_next_state = ST_CLEAR;
            default:                              w_next_state = RESET_STATE;
        endcase
    end

    always_comb begin
        s_waitrequest = 1'b1;
        clear_busy    = 1'b0;
        m_chipselect  = 1'b0;
        m_write       = 1'b0;
        m_address     = s_address;
        m_byteenable  = s_byteenable;
        m_writedata   = s_writedata;
        if (r_active) begin
            case (r_state)
                ST_CLEAR: begin
                    clear_busy   = 1'b1;
                    m_chipselect = 1'b1;
                    m_write      = 1'b1;
                    m_address    = w_clr_addr;
                    m_byteenable = '1;
                    m_writedata  = '0;
                end
                ST_RUN: begin
                    s_waitrequest = 1'b0;
                    m_chipselect  = s_read | s_write;
                    m_write       = s_write;
                end
                ST_DRAIN: begin
                    clear_busy = 1'b1;
                end
                default: begin
                    clear_busy = 1'b0;
                end
            endcase
        end
    end

    assign m_clken = 1'b1;

    // Bit 0 marks the cycle RAM data is returning; bit 1 marks the registered response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pipe <= 2'b00;
        end else begin
            r_rd_pipe <= {r_rd_pipe[0], w_rd_accept};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (r_rd_pipe[0]) begin
            r_readdata <= m_readdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_rw_clash) begin
            r_err <= 1'b1;
        end
    end

    assign s_readdata      = r_readdata;
    assign s_readdatavalid = r_rd_pipe[1];
    assign err_sticky      = r_err;

endmodule

// File: tb/tb_lms_ctr_mem_access_bridge.sv
// Directed + randomized bench for the bridge, with a byte-lane RAM and a word-level memory model.
module tb_lms_ctr_mem_access_bridge;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic        clk;
    logic        reset_n;
    logic [9:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [3:0]  s_byteenable;
    logic [31:0] s_writedata;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic        clear_req;
    logic        clear_busy;
    logic        err_sticky;
    logic [9:0]  m_address;
    logic        m_chipselect;
    logic        m_write;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic        m_clken;
    logic [31:0] m_readdata;

    lms_ctr_mem_access_bridge #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_byteenable    (s_byteenable),
        .s_writedata     (s_writedata),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .clear_req       (clear_req),
        .clear_busy      (clear_busy),
        .err_sticky      (err_sticky),
        .m_address       (m_address),
        .m_chipselect    (m_chipselect),
        .m_write         (m_write),
        .m_byteenable    (m_byteenable),
        .m_writedata     (m_writedata),
        .m_clken         (m_clken),
        .m_readdata      (m_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream single-port RAM with one-cycle registered read.
    logic [31:0] ramMem [0:DEPTH-1];
    always @(posedge clk) begin
        if (m_clken && m_chipselect) begin
            if (m_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_byteenable[b]) ramMem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
                end
            end else begin
                m_readdata <= ramMem[m_address];
            end
        end
    end

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    resp_t       expQ[$];
    logic [31:0] refMem [0:DEPTH-1];
    logic        expErr;
    int          cycleCount;
    int          vecCount;
    int          missCount;
    int          drainCycles;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  lanes);
        logic [31:0] result;
        result = oldWord;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) result[8*b +: 8] = newWord[8*b +: 8];
        end
        return result;
    endfunction

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycleCount);
        end
    endtask

    task automatic checkOutput();
        logic expValid;
        expValid = (expQ.size() > 0) && (expQ[0].due == cycleCount);
        checkEq("readdatavalid", 64'(s_readdatavalid), 64'(expValid));
        if (expValid) begin
            checkEq("readdata", 64'(s_readdata), 64'(expQ[0].data));
            void'(expQ.pop_front());
        end
        checkEq("err_sticky", 64'(err_sticky), 64'(expErr));
    endtask

    task automatic driveIdle();
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_address    = '0;
        s_byteenable = '0;
        s_writedata  = '0;
        clear_req    = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        cycleCount++;
        checkOutput();
    endtask

    // One RUN-mode request: check the combinational pass-through, update the model, clock it.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [9:0] a,
                                 input logic [3:0] be, input logic [31:0] wd, input logic clr);
        resp_t r;
        s_read       = rd;
        s_write      = wr;
        s_address    = a;
        s_byteenable = be;
        s_writedata  = wd;
        clear_req    = clr;
        #1;
        checkEq("run_bus", {s_waitrequest, m_chipselect, m_write, m_byteenable, m_address, m_writedata},
                {1'b0, rd | wr, wr, be, a, wd});
        if (rd && !wr) begin
            r.due  = cycleCount + 2;
            r.data = refMem[a];
            expQ.push_back(r);
        end
        if (wr) refMem[a] = mergeBytes(refMem[a], wd, be);
        if (rd && wr) expErr = 1'b1;
        nextCycle();
        driveIdle();
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        driveIdle();
        #1;
        checkEq("reset_vals",
                {s_waitrequest, s_readdatavalid, s_readdata, m_chipselect, m_write, clear_busy, err_sticky},
                {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        expQ.delete();
        expErr = 1'b0;
        nextCycle();
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        checkEq("busy_rise", 64'(clear_busy), 64'(1'b1));
    endtask

    // Walk the zero-fill; a non-negative abortAt stops early so a reset can be injected there.
    task automatic runClearPhase(input int abortAt);
        int stopAt;
        stopAt = (abortAt < 0) ? DEPTH : abortAt;
        for (int i = 0; i < stopAt; i++) begin
            checkEq("clear_bus",
                    {s_waitrequest, clear_busy, m_chipselect, m_write, m_clken, m_byteenable, m_writedata, m_address},
                    {5'b11111, 4'hF, 32'h0, 10'(i)});
            nextCycle();
        end
        if (abortAt < 0) begin
            checkEq("clear_exit", {s_waitrequest, clear_busy}, 2'b00);
            for (int k = 0; k < DEPTH; k++) refMem[k] = 32'h0;
        end
    endtask

    initial begin
        logic [9:0]  ra;
        logic [3:0]  rbe;
        logic [31:0] rwd;
        int          op;

        vecCount   = 0;
        missCount  = 0;
        cycleCount = 0;
        expErr     = 1'b0;
        for (int k = 0; k < DEPTH; k++) refMem[k] = 32'h0;
        driveIdle();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] power-up reset and zero-fill");
        applyReset();
        runClearPhase(-1);

        $display("[TB] read top word after clear");
        applyStimulus(1'b1, 1'b0, 10'd1023, 4'h0, 32'h0, 1'b0);
        idleCycles(3);

        $display("[TB] byte-lane write then read");
        applyStimulus(1'b0, 1'b1, 10'd5, 4'b0101, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 10'd5, 4'h0, 32'h0, 1'b0);
        idleCycles(3);

        $display("[TB] back-to-back reads");
        for (int a = 1; a <= 3; a++) applyStimulus(1'b0, 1'b1, 10'(a), 4'hF, $urandom, 1'b0);
        for (int a = 1; a <= 3; a++) applyStimulus(1'b1, 1'b0, 10'(a), 4'h0, 32'h0, 1'b0);
        idleCycles(3);

        $display("[TB] simultaneous read and write");
        applyStimulus(1'b1, 1'b1, 10'd7, 4'hF, 32'h12345678, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 10'd7, 4'h0, 32'h0, 1'b0);
        idleCycles(3);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            op  = int'($urandom_range(0, 15));
            ra  = 10'($urandom_range(0, 15));
            rbe = 4'($urandom_range(0, 15));
            rwd = $urandom;
            if (op < 6)        applyStimulus(1'b1, 1'b0, ra, rbe, rwd, 1'b0);
            else if (op < 12)  applyStimulus(1'b0, 1'b1, ra, rbe, rwd, 1'b0);
            else if (op == 15) applyStimulus(1'b1, 1'b1, ra, rbe, rwd, 1'b0);
            else               idleCycles(1);
        end
        idleCycles(3);

        $display("[TB] runtime clear with a read in the same cycle");
        applyStimulus(1'b1, 1'b0, 10'd9, 4'h0, 32'h0, 1'b1);
        drainCycles = 0;
        while (drainCycles < 4 && clear_busy === 1'b1 && m_write === 1'b0) begin
            checkEq("drain_bus", {s_waitrequest, m_chipselect}, 2'b10);
            drainCycles++;
            nextCycle();
        end
        checkEq("drain_len", 64'(drainCycles >= 1 && drainCycles <= 2), 64'(1'b1));
        runClearPhase(-1);
        checkEq("drain_resp_done", 64'(expQ.size()), 64'(0));

        $display("[TB] reset with reads in flight and mid-clear");
        applyStimulus(1'b1, 1'b0, 10'd11, 4'h0, 32'h0, 1'b0);
        s_read    = 1'b1;
        s_address = 10'd12;
        #2;
        applyReset();
        runClearPhase(500);
        applyReset();
        runClearPhase(-1);

        applyStimulus(1'b0, 1'b1, 10'd100, 4'b1010, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b1, 1'b0, 10'd100, 4'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 10'd1023, 4'h0, 32'h0, 1'b0);
        idleCycles(3);
        checkEq("final_resp_done", 64'(expQ.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
